// File: rtl/gcode_command_dispatcher.sv
// G-code command dispatcher: buffers commands in a small FIFO, decodes modal/move codes
// and hands absolute move targets to a motion controller. Optional macro: COORD_SATURATE_EN.
module gcode_command_dispatcher #(
    parameter int COORD_W    = 14,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               block,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [3:0]         cmd,
    input  logic [COORD_W-1:0] x_in,
    input  logic [COORD_W-1:0] y_in,
    output logic               move_valid,
    input  logic               move_ready,
    output logic [COORD_W-1:0] x_value,
    output logic [COORD_W-1:0] y_value,
    output logic [4:0]         state_reg,
    output logic               halted,
    output logic               cmd_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 4 + 2 * COORD_W;

    localparam logic [3:0] C_G00 = 4'd0, C_G01 = 4'd1, C_G20 = 4'd2, C_G21 = 4'd3,
                           C_G90 = 4'd4, C_G91 = 4'd5, C_M2  = 4'd6, C_M6  = 4'd7,
                           C_M72 = 4'd8;

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_ISSUE, S_HALT} state_t;

    state_t              r_state, w_next;
    logic [1:0]          r_sync;
    logic                w_run, w_push, w_pop, w_full, w_empty;
    logic [EW-1:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
    logic [AW:0]         r_count;
    logic [3:0]          r_cmd;
    logic [COORD_W-1:0]  r_xin, r_yin, r_x, r_y;
    logic                r_linear, r_inches, r_rel, r_raise, r_tool, r_err;

    // Popping waits for the locally synchronised reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_sync <= 2'b00;
        else          r_sync <= {r_sync[0], 1'b1};
    end
    assign w_run = r_sync[1];

    assign w_full    = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign cmd_ready = ~w_full;
    assign w_push    = cmd_valid & ~w_full & ~block;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {cmd, x_in, y_in};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (block) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cmd <= '0;
            r_xin <= '0;
            r_yin <= '0;
        end else if (w_pop) begin
            {r_cmd, r_xin, r_yin} <= r_mem[r_rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_pop) w_next = S_DECODE;
            S_DECODE: begin
                case (r_cmd)
                    C_G00, C_G01, C_M6, C_M72: w_next = S_ISSUE;
                    C_M2:                      w_next = S_HALT;
                    default:                   w_next = S_IDLE;
                endcase
            end
            S_ISSUE:  if (move_ready) w_next = S_IDLE;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_IDLE;
        endcase
        if (block) w_next = S_IDLE;
    end

    always_comb begin
        move_valid = (r_state == S_ISSUE);
        halted     = (r_state == S_HALT);
        w_pop      = (r_state == S_IDLE) & ~w_empty & w_run & ~block;
    end

    function automatic logic [COORD_W-1:0] f_add(input logic [COORD_W-1:0] a,
                                                 input logic [COORD_W-1:0] b);
        logic [COORD_W:0] s;
        s = {a[COORD_W-1], a} + {b[COORD_W-1], b};
`ifdef COORD_SATURATE_EN
        if (s[COORD_W] != s[COORD_W-1])
            return s[COORD_W] ? {1'b1, {(COORD_W-1){1'b0}}} : {1'b0, {(COORD_W-1){1'b1}}};
`endif
        return s[COORD_W-1:0];
    endfunction

    // Modal bits and targets; block restores modal defaults but keeps the last target.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x      <= '0;
            r_y      <= '0;
            r_linear <= 1'b0;
            r_inches <= 1'b1;
            r_rel    <= 1'b0;
            r_raise  <= 1'b1;
            r_tool   <= 1'b0;
            r_err    <= 1'b0;
        end else if (block) begin
            r_linear <= 1'b0;
            r_inches <= 1'b1;
            r_rel    <= 1'b0;
            r_raise  <= 1'b1;
            r_tool   <= 1'b0;
            r_err    <= 1'b0;
        end else if (r_state == S_DECODE) begin
            if (r_cmd <= C_M72 && r_cmd != C_M6) r_tool <= 1'b0;
            case (r_cmd)
                C_G00, C_G01: begin
                    r_linear <= (r_cmd == C_G01);
                    r_x      <= r_rel ? f_add(r_x, r_xin) : r_xin;
                    r_y      <= r_rel ? f_add(r_y, r_yin) : r_yin;
                end
                C_G20:   r_inches <= 1'b1;
                C_G21:   r_inches <= 1'b0;
                C_G90:   r_rel    <= 1'b0;
                C_G91:   r_rel    <= 1'b1;
                C_M2:    ;
                C_M6: begin
                    r_tool <= 1'b1;
                    r_x    <= r_xin;
                end
                C_M72:   r_raise  <= ~r_raise;
                default: r_err    <= 1'b1;
            endcase
        end
    end

    assign x_value   = r_x;
    assign y_value   = r_y;
    assign cmd_err   = r_err;
    assign state_reg = {r_tool, r_raise, r_rel, r_inches, r_linear};
endmodule

// File: tb/tb_gcode_command_dispatcher.sv
// Scoreboard bench for gcode_command_dispatcher: directed commands queue their expected
// moves; a monitor checks every move handshake against the queue.
module tb_gcode_command_dispatcher;
    localparam int CW = 14;
    localparam int FD = 4;
    typedef logic [CW-1:0] crd_t;
    typedef struct packed { crd_t x; crd_t y; logic [4:0] st; } exp_t;

    logic       clk = 1'b0, reset_n = 1'b0, block = 1'b0, cmd_valid = 1'b0, move_ready = 1'b0;
    logic [3:0] cmd = '0;
    crd_t       x_in = '0, y_in = '0, x_value, y_value;
    logic       cmd_ready, move_valid, halted, cmd_err;
    logic [4:0] state_reg;

    exp_t q[$];
    exp_t m_a, m_e;
    int   n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    gcode_command_dispatcher #(.COORD_W(CW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset_n(reset_n), .block(block), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd(cmd), .x_in(x_in), .y_in(y_in),
        .move_valid(move_valid), .move_ready(move_ready), .x_value(x_value),
        .y_value(y_value), .state_reg(state_reg), .halted(halted), .cmd_err(cmd_err)
    );

    always @(negedge clk) begin
        if (reset_n && move_valid && move_ready) begin
            m_a = '{x_value, y_value, state_reg};
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_move: got x=%0d y=%0d st=%b, no move expected",
                         $signed(x_value), $signed(y_value), state_reg);
            end else begin
                m_e = q.pop_front();
                if (m_a !== m_e) begin
                    n_err++;
                    $display("FAIL move: got x=%0d y=%0d st=%b want x=%0d y=%0d st=%b",
                             $signed(m_a.x), $signed(m_a.y), m_a.st,
                             $signed(m_e.x), $signed(m_e.y), m_e.st);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic ex(input int x, input int y, input logic [4:0] st);
        q.push_back('{crd_t'(x), crd_t'(y), st});
    endtask

    task automatic push(input logic [3:0] c, input int x, input int y);
        int t = 0;
        while (!cmd_ready && t < 200) begin
            tick();
            t++;
        end
        if (!cmd_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL push_timeout: cmd_ready got 0 want 1 (code %0d)", c);
        end else begin
            cmd_valid = 1'b1;
            cmd       = c;
            x_in      = crd_t'(x);
            y_in      = crd_t'(y);
            tick();
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while (q.size() != 0 && t < 200) begin
            tick();
            t++;
        end
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending moves want 0", q.size());
            q.delete();
        end
        repeat (2) tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        block = 1'b0;
        cmd_valid = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // reset values
        repeat (2) tick();
        chk("rst_cmd_ready",  32'(cmd_ready),  32'd1);
        chk("rst_move_valid", 32'(move_valid), 32'd0);
        chk("rst_halted",     32'(halted),     32'd0);
        chk("rst_cmd_err",    32'(cmd_err),    32'd0);
        chk("rst_x",          32'(x_value),    32'd0);
        chk("rst_y",          32'(y_value),    32'd0);
        chk("rst_state",      32'(state_reg),  32'b01010);
        reset_n = 1'b1;
        repeat (3) tick();

        // absolute move and push-to-valid latency
        move_ready = 1'b1;
        push(4'd4, 0, 0);
        repeat (5) tick();
        ex(100, -50, 5'b01011);
        push(4'd1, 100, -50);
        chk("lat_push", 32'(move_valid), 32'd0);
        tick();
        chk("lat_pop", 32'(move_valid), 32'd0);
        tick();
        chk("lat_decode", 32'(move_valid), 32'd1);
        wait_drain();

        // relative arithmetic at the coordinate limits
        do_reset();
        push(4'd5, 0, 0);
        ex(8000, -5000, 5'b01111);
        push(4'd1, 8000, -5000);
`ifdef COORD_SATURATE_EN
        ex(8191, -8192, 5'b01111);
        ex(191, -8192, 5'b01111);
`else
        ex(-384, 6384, 5'b01111);
        ex(8000, 6384, 5'b01111);
`endif
        push(4'd1, 8000, -5000);
        push(4'd1, -8000, 0);
        push(4'd4, 0, 0);
        push(4'd3, 0, 0);
        ex(5, 6, 5'b01000);
        push(4'd0, 5, 6);
        wait_drain();

        // backpressure: one in ISSUE, four buffered
        move_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            ex(i, 10 + i, 5'b01001);
            push(4'd1, i, 10 + i);
        end
        repeat (2) tick();
        chk("full_cmd_ready", 32'(cmd_ready),  32'd0);
        chk("full_move_valid", 32'(move_valid), 32'd1);
        chk("full_hold_x",    32'(x_value),    32'(crd_t'(1)));
        move_ready = 1'b1;
        wait_drain();
        chk("drained_cmd_ready", 32'(cmd_ready), 32'd1);

        // halt, fill, then block flush (a push alongside block is dropped)
        push(4'd6, 0, 0);
        push(4'd1, 7, 7);
        repeat (6) tick();
        chk("halt_halted",     32'(halted),     32'd1);
        chk("halt_move_valid", 32'(move_valid), 32'd0);
        for (int i = 0; i < 3; i++) push(4'd1, 20 + i, 0);
        chk("halt_full", 32'(cmd_ready), 32'd0);
        block = 1'b1;
        cmd_valid = 1'b1;
        cmd = 4'd1;
        x_in = crd_t'(9);
        tick();
        block = 1'b0;
        cmd_valid = 1'b0;
        chk("blk_halted",    32'(halted),    32'd0);
        chk("blk_state",     32'(state_reg), 32'b01010);
        chk("blk_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("blk_keep_x",    32'(x_value),   32'(crd_t'(5)));
        chk("blk_keep_y",    32'(y_value),   32'(crd_t'(15)));
        repeat (8) tick();
        chk("blk_no_move", 32'(move_valid), 32'd0);

        // illegal code, M72 toggles, M6 tool change, block clears error
        push(4'd12, 0, 0);
        repeat (4) tick();
        chk("err_set", 32'(cmd_err), 32'd1);
        ex(5, 15, 5'b00010);
        push(4'd8, 0, 0);
        ex(5, 15, 5'b01010);
        push(4'd8, 0, 0);
        wait_drain();
        chk("err_sticky", 32'(cmd_err),   32'd1);
        chk("m72_state",  32'(state_reg), 32'b01010);
        ex(3, 15, 5'b11010);
        push(4'd7, 3, 99);
        wait_drain();
        block = 1'b1;
        tick();
        block = 1'b0;
        chk("err_clear",  32'(cmd_err),   32'd0);
        chk("tool_clear", 32'(state_reg), 32'b01010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/gcode_command_dispatcher.md
GCODE_COMMAND_DISPATCHER -- requirements
Module: gcode_command_dispatcher

Interface
REQ-001 SHALL provide parameter COORD_W, default 14: coordinate width in bits, two's complement, legal range 8..24.
REQ-002 SHALL provide parameter FIFO_DEPTH, default 4: command buffer depth, power of two, legal range 2..16.
REQ-003 SHALL provide ports:
- clk  in  1  single clock; all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- block  in  1  synchronous flush and modal restore.
- cmd_valid  in  1  upstream command present.
- cmd_ready  out  1  buffer not full.
- cmd  in  4  command code.
- x_in, y_in  in  COORD_W each  command operands.
- move_valid  out  1  move/tool request present.
- move_ready  in  1  motion controller accepts request.
- x_value, y_value  out  COORD_W each  absolute target.
- state_reg  out  5  {tool_change, raise_tool, relative, inches, linear}.
- halted  out  1  M2 seen.
- cmd_err  out  1  sticky illegal-code flag.

Function
REQ-004 SHALL decode codes G00=0, G01=1, G20=2, G21=3, G90=4, G91=5, M2=6, M6=7, M72=8; codes 9..15 SHALL be illegal.
REQ-005 SHALL push {cmd, x_in, y_in} into the FIFO on every cycle where cmd_valid and cmd_ready are both high and block is low.
REQ-006 SHALL drive cmd_ready = FIFO not full; it SHALL NOT depend combinationally on cmd_valid.
REQ-007 SHALL implement FSM states IDLE, DECODE, ISSUE, HALT.
REQ-008 IDLE SHALL pop one entry when the FIFO is non-empty and go to DECODE next cycle.
REQ-009 DECODE SHALL update modal bits as follows:
- G20/G21: inches 1/0.
- G90/G91: relative 0/1.
- G00: linear 0.
- G01: linear 1.
- M6: tool_change 1.
- M72: toggle raise_tool.
REQ-010 Every code other than M6 SHALL clear tool_change in DECODE.
REQ-011 G00/G01 in DECODE SHALL load the targets and go to ISSUE:
- absolute mode: x_value/y_value = operands.
- relative mode: x_value/y_value = current value + operand, in COORD_W-bit arithmetic.
REQ-012 M6 in DECODE SHALL load x_value = x_in (tool number), leave y_value unchanged, and go to ISSUE.
REQ-013 M72 in DECODE SHALL go to ISSUE.
REQ-014 Modal-only codes (G20, G21, G90, G91) in DECODE SHALL return to IDLE.
REQ-015 M2 in DECODE SHALL set halted and go to HALT.
REQ-016 An illegal code in DECODE SHALL set cmd_err, change nothing else, and return to IDLE.
REQ-017 ISSUE SHALL hold move_valid high with x_value, y_value and state_reg stable until move_ready is high.
REQ-018 ISSUE SHALL go to IDLE in the cycle move_ready is seen; move_ready outside ISSUE SHALL be ignored.
REQ-019 Minimum FIFO-push-to-move_valid latency SHALL be 3 cycles (push, pop, decode); sustained throughput SHALL be one command per 3 cycles with move_ready held high.
REQ-020 HALT SHALL pop nothing; pushes SHALL continue until the FIFO is full.
REQ-021 block high SHALL, on that edge, override all other actions:
- empty the FIFO and drop any simultaneous push;
- enter IDLE and deassert move_valid;
- clear halted and cmd_err;
- restore modal defaults linear 0, inches 1, relative 0, raise_tool 1, tool_change 0.
REQ-022 block SHALL leave x_value and y_value unchanged.
REQ-023 A push and a pop in the same cycle with the FIFO full SHALL NOT be possible, since cmd_ready is low; a push and a pop with the FIFO partially filled SHALL both succeed and keep the count unchanged.

Reset
REQ-024 While reset_n is low, all state SHALL take these values asynchronously:
- FSM IDLE; FIFO empty (cmd_ready 1).
- move_valid 0, halted 0, cmd_err 0.
- x_value 0, y_value 0.
- state_reg 5'b01010 (raise_tool 1, inches 1).
REQ-025 Reset deassertion SHALL be synchronised to clk internally; the first pop SHALL occur no earlier than the second clk edge after deassertion.

Configuration
REQ-026 With COORD_SATURATE_EN defined, relative addition SHALL clamp to the most positive or most negative COORD_W value on overflow.
REQ-027 Without COORD_SATURATE_EN, relative addition SHALL wrap modulo 2^COORD_W.

Verification
REQ-028 Reset, then push G90, then G01 x=100 y=-50 -> move_valid high 3 cycles after the G01 push, x_value=100, y_value=-50, state_reg=01011.
REQ-029 Push G91, then G01 x=8000 y=0 twice (COORD_W=14) -> wraps to x=-384 without COORD_SATURATE_EN; clamps to x=8191 with it.
REQ-030 Hold move_ready low, push 5 commands with FIFO_DEPTH=4 -> cmd_ready low after 4 entries are buffered and one is in ISSUE; nothing lost after move_ready rises.
REQ-031 Push M2 then G01 -> halted=1, G01 not popped; pulse block -> FIFO empty, halted=0, state_reg=01010.
REQ-032 Push code 12, then M72 twice -> cmd_err=1 and sticky; raise_tool 1->0->1, with one move_valid handshake per M72.
